// File: rtl/line_clear_sequencer.sv
// line_clear_sequencer
//   Runs a line-clear pass over the board RAM after a piece has been placed.
//   Each row is read from the bottom row to the top row. Completely filled
//   rows are dropped. The surviving rows are compacted downward in place, and
//   the vacated top rows are zero-filled. The number of removed rows is then
//   reported. The block owns the RAM port exclusively while busy.
//
// Ports
//   Clk           : clock, everything on posedge
//   RESET         : synchronous active-high reset
//   start         : one-cycle pass request, honoured only when idle
//   busy          : high from the first READ cycle through the DONE cycle
//   done          : one-cycle completion pulse
//   lines_cleared : full rows removed by the last pass (updates with done)
//   rd_en/rd_addr : RAM read strobe / row address
//   rd_data       : RAM read data, valid one cycle after rd_en
//   wr_en/wr_addr/wr_data : RAM write strobe / row address / row data
module line_clear_sequencer #(
  parameter int ROWS  = 20,
  parameter int WIDTH = 10,
  parameter int AW    = $clog2(ROWS),
  parameter int CW    = $clog2(ROWS + 1)
) (
  input  logic             Clk,
  input  logic             RESET,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    lines_cleared,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data
);

  typedef enum logic [2:0] {IDLE, READ, EVAL, FILL, DONE} state_t;

  localparam logic [AW-1:0]    LAST_ROW = AW'(ROWS - 1);
  localparam logic [CW-1:0]    K_MAX    = CW'(ROWS);
  localparam logic [WIDTH-1:0] FULL_ROW = {WIDTH{1'b1}};

  state_t        state, state_nxt;
  logic [AW-1:0] r, r_nxt;        // read pointer
  // Write pointer, one bit wider than an address. It ends the scan at k-1,
  // which is -1 (all ones) when nothing was cleared.
  logic [AW:0]   w, w_nxt;
  logic [CW-1:0] k, k_nxt;        // rows cleared so far in this pass
  logic [CW-1:0] lines_nxt;

  always_ff @(posedge Clk) begin
    if (RESET) begin
      state         <= IDLE;
      r             <= '0;
      w             <= '0;
      k             <= '0;
      lines_cleared <= '0;
    end else begin
      state         <= state_nxt;
      r             <= r_nxt;
      w             <= w_nxt;
      k             <= k_nxt;
      lines_cleared <= lines_nxt;
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    w_nxt     = w;
    k_nxt     = k;
    lines_nxt = lines_cleared;
    rd_en     = 1'b0;
    rd_addr   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    done      = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          r_nxt     = LAST_ROW;
          w_nxt     = {1'b0, LAST_ROW};
          k_nxt     = '0;
          state_nxt = READ;
        end
      end

      READ: begin
        rd_en     = 1'b1;
        rd_addr   = r;
        state_nxt = EVAL;
      end

      EVAL: begin
        if (rd_data == FULL_ROW) begin
          // A dropped row leaves w in place, so the next survivor fills the gap.
          if (k != K_MAX) k_nxt = k + CW'(1);
        end else begin
          // w == r means no rows have been dropped below this one yet, so the
          // row is already in its final place and no write is needed.
          if (w != {1'b0, r}) begin
            wr_en   = 1'b1;
            wr_addr = w[AW-1:0];
            wr_data = rd_data;
          end
          w_nxt = w - (AW + 1)'(1);
        end
        if (r == '0) begin
          // Use the updated count, because row 0 itself may have been full.
          if (k_nxt != '0) begin
            state_nxt = FILL;
          end else begin
            state_nxt = DONE;
            lines_nxt = k_nxt;
          end
        end else begin
          r_nxt     = r - AW'(1);
          state_nxt = READ;
        end
      end

      FILL: begin
        wr_en   = 1'b1;
        wr_addr = w[AW-1:0];
        w_nxt   = w - (AW + 1)'(1);
        if (w == '0) begin
          state_nxt = DONE;
          lines_nxt = k;
        end
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
